// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: opcodes, FSM states,
// datapath mux codes and the packed control-strobe bundle.
package multicycle_control_pkg;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_ADDIEX  = 4'd8,
    S_ADDIWB  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // States that wait on the memory before moving on.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. Strobes are level signals sampled by the datapath on
// the rising clock edge; there is no valid/ready pairing beyond mem_ready, which the
// memory raises in the cycle an access completes and which only matters in memory states.
interface multicycle_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control_mem_wait_counter.sv
// Fixed-latency memory wait counter: done in the cycle the count reaches MEM_LAT-1.
// Saturates at that value so it can never wrap; clear returns it to zero.
module multicycle_control_mem_wait_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);
  localparam int unsigned CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'((MEM_LAT < 1) ? 0 : MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !done_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/
// write-back for lw, sw, R-type, addi, beq and j, with variable memory latency.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_LAT      = 1,
  parameter bit          USE_READY    = 1'b0,
  parameter bit          TRAP_ILLEGAL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus,
  output state_t                state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   in_mem;
  logic   cnt_done;
  logic   mem_done;

  // zero only qualifies the datapath's conditional PC load; the FSM never branches on it.
  logic unused_zero;
  assign unused_zero = bus.zero;

  assign in_mem   = is_mem_state(state_q);
  assign mem_done = in_mem && (USE_READY ? bus.mem_ready : cnt_done);

  multicycle_control_mem_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_mem || mem_done),
    .enable_i (in_mem),
    .done_o   (cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ILLEGAL: if (!TRAP_ILLEGAL) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes that commit state (ir_write, pc_write, sw's instr_done) wait for mem_done.
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_done;
        ctrl.pc_write  = mem_done;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_done;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal_op = 1'b1;
      default:   ctrl = '0;
    endcase
    // Reset sits in FETCH, but nothing may be strobed while it is held.
    if (rst) begin
      ctrl = '0;
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: four instances cover default latency,
// MEM_LAT=3, the mem_ready handshake and the illegal-opcode trap.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // {pcw,pcwc,iord,mrd,mwr,m2r,irw,rw,rdst,asa,asb[2],aop[2],psrc[2],done,ill}
  localparam logic [17:0] V_ZERO   = 18'b0;
  localparam logic [17:0] V_F_DONE = 18'b1_0_0_1_0_0_1_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_F_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] V_MADR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_MRD    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MWB    = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] V_MWR_D  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] V_MWR_W  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] V_RWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] V_AEX    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_AWB    = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] V_BR     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] V_JMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] V_ILL    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  multicycle_control_if ifa();
  multicycle_control_if ifb();
  multicycle_control_if ifc();
  multicycle_control_if ifd();
  state_t state_a, state_b, state_c, state_d;

  multicycle_control #(.MEM_LAT(1), .USE_READY(1'b0), .TRAP_ILLEGAL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.master), .state_o(state_a));
  multicycle_control #(.MEM_LAT(3), .USE_READY(1'b0), .TRAP_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.master), .state_o(state_b));
  multicycle_control #(.MEM_LAT(1), .USE_READY(1'b1), .TRAP_ILLEGAL(1'b0)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.master), .state_o(state_c));
  multicycle_control #(.MEM_LAT(1), .USE_READY(1'b0), .TRAP_ILLEGAL(1'b1)) dut_d (
    .clk(clk), .rst(rst), .bus(ifd.master), .state_o(state_d));

  logic [17:0] out_a, out_b, out_c, out_d;
  assign out_a = {ifa.pc_write, ifa.pc_write_cond, ifa.i_or_d, ifa.mem_read, ifa.mem_write,
                  ifa.mem_to_reg, ifa.ir_write, ifa.reg_write, ifa.reg_dst, ifa.alu_src_a,
                  ifa.alu_src_b, ifa.alu_op, ifa.pc_source, ifa.instr_done, ifa.illegal_op};
  assign out_b = {ifb.pc_write, ifb.pc_write_cond, ifb.i_or_d, ifb.mem_read, ifb.mem_write,
                  ifb.mem_to_reg, ifb.ir_write, ifb.reg_write, ifb.reg_dst, ifb.alu_src_a,
                  ifb.alu_src_b, ifb.alu_op, ifb.pc_source, ifb.instr_done, ifb.illegal_op};
  assign out_c = {ifc.pc_write, ifc.pc_write_cond, ifc.i_or_d, ifc.mem_read, ifc.mem_write,
                  ifc.mem_to_reg, ifc.ir_write, ifc.reg_write, ifc.reg_dst, ifc.alu_src_a,
                  ifc.alu_src_b, ifc.alu_op, ifc.pc_source, ifc.instr_done, ifc.illegal_op};
  assign out_d = {ifd.pc_write, ifd.pc_write_cond, ifd.i_or_d, ifd.mem_read, ifd.mem_write,
                  ifd.mem_to_reg, ifd.ir_write, ifd.reg_write, ifd.reg_dst, ifd.alu_src_a,
                  ifd.alu_src_b, ifd.alu_op, ifd.pc_source, ifd.instr_done, ifd.illegal_op};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: leaves every instance in FETCH cycle 1, 1 time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({out_a, out_b, out_c, out_d} !== {4{V_ZERO}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h %h %h %h expected all 0", out_a, out_b, out_c, out_d);
    end
    n_tests++;
    if (state_a !== S_FETCH) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", state_a, S_FETCH);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({out_a, out_b, out_c, out_d} !== {V_F_DONE, V_F_WAIT, V_F_WAIT, V_F_DONE}) begin
      n_fail++;
      $display("FAIL reset_release: got %b %b %b %b expected %b %b %b %b",
               out_a, out_b, out_c, out_d, V_F_DONE, V_F_WAIT, V_F_WAIT, V_F_DONE);
    end
  endtask

  task automatic test_lw();
    logic [17:0] exp_q[$];
    exp_q = '{V_F_DONE, V_DEC, V_MADR, V_MRD, V_MWB};
    do_reset();
    ifa.op = OP_LW;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 3) ifa.op = 6'h3F;  // past the last op sample point: must be ignored
      #1;
      n_tests++;
      if (out_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lw c%0d: got %b expected %b", i + 1, out_a, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (state_a !== S_FETCH) begin
      n_fail++;
      $display("FAIL lw_return: got state %0d expected %0d", state_a, S_FETCH);
    end
  endtask

  task automatic test_rtype_addi();
    logic [17:0] exp_q[$];
    logic [5:0]  op_q[$];
    exp_q = '{V_F_DONE, V_DEC, V_EXEC, V_RWB, V_F_DONE, V_DEC, V_AEX, V_AWB};
    op_q  = '{OP_R, OP_R, OP_R, OP_R, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    for (int i = 0; i < exp_q.size(); i++) begin
      ifa.op = op_q[i];
      #1;
      n_tests++;
      if (out_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL r_addi c%0d: got %b expected %b", i + 1, out_a, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch_jump();
    logic [17:0] exp_q[$];
    logic [5:0]  op_q[$];
    exp_q = '{V_F_DONE, V_DEC, V_BR, V_F_DONE, V_DEC, V_JMP};
    op_q  = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
    ifa.zero = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      ifa.op = op_q[i];
      #1;
      n_tests++;
      if (out_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL beq_j c%0d: got %b expected %b", i + 1, out_a, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    ifa.zero = 1'b0;
  endtask

  task automatic test_illegal_pulse();
    logic [17:0] exp_q[$];
    exp_q = '{V_F_DONE, V_DEC, V_ILL};
    ifa.op = 6'h3F;
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      n_tests++;
      if (out_a !== exp_q[i]) begin
        n_fail++;
        $display("FAIL illegal_pulse c%0d: got %b expected %b", i + 1, out_a, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    #1;
    n_tests++;
    if (state_a !== S_FETCH || out_a !== V_F_DONE) begin
      n_fail++;
      $display("FAIL illegal_return: got state %0d out %b expected state %0d out %b",
               state_a, out_a, S_FETCH, V_F_DONE);
    end
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    ifa.op = OP_LW;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    n_tests++;
    if (out_a !== V_MRD) begin
      n_fail++;
      $display("FAIL abort_in_memrd: got %b expected %b", out_a, V_MRD);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_a !== V_ZERO || state_a !== S_FETCH) begin
      n_fail++;
      $display("FAIL abort_immediate: got out %b state %0d expected 0 state %0d",
               out_a, state_a, S_FETCH);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (out_a !== V_ZERO) begin
      n_fail++;
      $display("FAIL abort_no_wb: got %b expected 0", out_a);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_a !== V_F_DONE) begin
      n_fail++;
      $display("FAIL abort_refetch: got %b expected %b", out_a, V_F_DONE);
    end
  endtask

  task automatic test_sw_lat3();
    logic [17:0] exp_q[$];
    exp_q = '{V_F_WAIT, V_F_WAIT, V_F_DONE, V_DEC, V_MADR, V_MWR_W, V_MWR_W, V_MWR_D, V_F_WAIT};
    ifb.op = OP_SW;
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      n_tests++;
      if (out_b !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sw_lat3 c%0d: got %b expected %b", i + 1, out_b, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ready();
    logic [17:0] exp_q[$];
    logic        rdy_q[$];
    exp_q = '{V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_WAIT, V_F_DONE, V_DEC, V_MADR,
              V_MRD, V_MRD, V_MWB, V_F_DONE};
    rdy_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ifc.op = OP_LW;
    ifc.mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      ifc.mem_ready = rdy_q[i];
      #1;
      n_tests++;
      if (out_c !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ready c%0d: got %b expected %b", i + 1, out_c, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    ifc.mem_ready = 1'b0;
  endtask

  task automatic test_trap();
    logic [17:0] exp_q[$];
    exp_q = '{V_F_DONE, V_DEC, V_ILL, V_ILL, V_ILL, V_ILL};
    ifd.op = 6'h3F;
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      n_tests++;
      if (out_d !== exp_q[i]) begin
        n_fail++;
        $display("FAIL trap c%0d: got %b expected %b", i + 1, out_d, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (state_d !== S_ILLEGAL) begin
      n_fail++;
      $display("FAIL trap_hold: got state %0d expected %0d", state_d, S_ILLEGAL);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_d !== V_ZERO) begin
      n_fail++;
      $display("FAIL trap_reset: got %b expected 0", out_d);
    end
    ifd.op = OP_R;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_tests++;
    if (out_d !== V_F_DONE || state_d !== S_FETCH) begin
      n_fail++;
      $display("FAIL trap_release: got out %b state %0d expected %b state %0d",
               out_d, state_d, V_F_DONE, S_FETCH);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    ifa.op = OP_R; ifa.zero = 1'b0; ifa.mem_ready = 1'b0;
    ifb.op = OP_R; ifb.zero = 1'b0; ifb.mem_ready = 1'b0;
    ifc.op = OP_R; ifc.zero = 1'b0; ifc.mem_ready = 1'b0;
    ifd.op = OP_R; ifd.zero = 1'b0; ifd.mem_ready = 1'b0;

    test_reset();
    test_lw();
    test_rtype_addi();
    test_branch_jump();
    test_illegal_pulse();
    test_reset_mid_memrd();
    test_sw_lat3();
    test_ready();
    test_trap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
